// File: rtl/packager_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// packager_ctrl_pkg: state encoding and defaults for packager_ctrl (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package packager_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_ARM     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  localparam int FLUSH_CYCLES_DEF = 4;
  localparam int FLUSH_CNT_W      = 4;

endpackage

`default_nettype wire

// File: rtl/packager_ctrl_wdog.sv
// ---------------------------------------------------------------------------
// packager_ctrl_wdog: cycle watchdog, flags the cycle that reaches the limit (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module packager_ctrl_wdog (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic        clear,
  input  logic [31:0] limit,
  output logic        expired
);

  logic [31:0] count;
  logic [31:0] count_next;

  assign count_next = count + 32'd1;

  // count_next is the number of active cycles including the current one
  assign expired = active && !clear && (limit != 32'd0) && (count_next == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (!active || clear) begin
      count <= 32'd0;
    end else begin
      count <= count_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/packager_ctrl.sv
// ---------------------------------------------------------------------------
// packager_ctrl: capture-run controller for a video packager (rev 1.0)
// Define PACKAGER_CTRL_TIMEOUT_EN to add the watchdog and ERROR state.
// ---------------------------------------------------------------------------
`default_nettype none

module packager_ctrl
  import packager_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic             video_clk,
  input  logic             video_resetn,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] lines_per_frame,
  input  logic [CNT_W-1:0] frames_req,
  input  logic [31:0]      timeout_cycles,
  input  logic             video_start_frame,
  input  logic             pkg_tlast,
  output logic             pkg_enable,
  output logic             pkg_soft_reset,
  output logic [CNT_W-1:0] pkg_line_count,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             error,
  output logic [CNT_W-1:0] frame_count
);

  localparam logic [CNT_W-1:0]       CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_t                 state;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0]       frames_lat;
  logic                   tlast_q;
  logic                   frame_end;
  logic                   accept;
  logic [CNT_W-1:0]       count_inc;
  logic                   wd_expired;

  assign frame_end = (state == ST_CAPTURE) && pkg_tlast && !tlast_q;
  assign accept    = start && !stop && (lines_per_frame != '0);
  assign count_inc = (&frame_count) ? frame_count : frame_count + CNT_ONE;

`ifdef PACKAGER_CTRL_TIMEOUT_EN
  logic wd_active;
  logic wd_clear;

  assign wd_active = (state == ST_ARM) || (state == ST_CAPTURE);
  assign wd_clear  = video_start_frame || frame_end;

  packager_ctrl_wdog u_wdog (
    .clk     (video_clk),
    .rst_n   (video_resetn),
    .active  (wd_active),
    .clear   (wd_clear),
    .limit   (timeout_cycles),
    .expired (wd_expired)
  );
`else
  logic unused_timeout;

  assign unused_timeout = ^timeout_cycles;
  assign wd_expired     = 1'b0;
`endif

  always_ff @(posedge video_clk or negedge video_resetn) begin
    if (!video_resetn) begin
      state          <= ST_IDLE;
      flush_cnt      <= '0;
      frames_lat     <= '0;
      tlast_q        <= 1'b0;
      pkg_enable     <= 1'b0;
      pkg_soft_reset <= 1'b0;
      pkg_line_count <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      error          <= 1'b0;
      frame_count    <= '0;
    end else begin
      tlast_q <= pkg_tlast;
      done    <= 1'b0;
      aborted <= 1'b0;

      // Stop outranks every other transition while busy
      if (stop && busy) begin
        state          <= ST_IDLE;
        aborted        <= 1'b1;
        pkg_enable     <= 1'b0;
        pkg_soft_reset <= 1'b1;
        busy           <= 1'b0;
        if (frame_end) frame_count <= count_inc;
      end else begin
        case (state)
          ST_IDLE, ST_ERROR: begin
            if (accept) begin
              state          <= ST_FLUSH;
              flush_cnt      <= FLUSH_LOAD;
              frames_lat     <= frames_req;
              pkg_line_count <= lines_per_frame - CNT_ONE;
              frame_count    <= '0;
              pkg_soft_reset <= 1'b1;
              pkg_enable     <= 1'b0;
              busy           <= 1'b1;
              error          <= 1'b0;
            end else if (state == ST_IDLE) begin
              pkg_soft_reset <= 1'b0;
            end
          end
          ST_FLUSH: begin
            if (flush_cnt == '0) begin
              state          <= ST_ARM;
              pkg_soft_reset <= 1'b0;
              pkg_enable     <= 1'b1;
            end else begin
              flush_cnt <= flush_cnt - 1'b1;
            end
          end
          ST_ARM, ST_CAPTURE: begin
            if (state == ST_ARM && video_start_frame) begin
              state <= ST_CAPTURE;
            end else if (frame_end) begin
              frame_count <= count_inc;
              pkg_enable  <= 1'b0;
              if (frames_lat != '0 && count_inc == frames_lat) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state          <= ST_FLUSH;
                flush_cnt      <= FLUSH_LOAD;
                pkg_soft_reset <= 1'b1;
              end
            end else if (wd_expired) begin
              state          <= ST_ERROR;
              error          <= 1'b1;
              pkg_enable     <= 1'b0;
              pkg_soft_reset <= 1'b1;
              busy           <= 1'b0;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state          <= ST_IDLE;
            pkg_enable     <= 1'b0;
            pkg_soft_reset <= 1'b0;
            busy           <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
